// File: rtl/bsg_link_upstream_piso_credit.sv
// bsg_link_upstream_piso_credit
//   Upstream link serializer with credit-based flow control. A wide core word
//   is accepted over valid/ready and shifted out LSB-first, one BEAT-wide slice
//   per cycle across CHANNELS lockstep channels. Each beat consumes one credit,
//   and each io_token_i pulse returns CREDITS_PER_TOKEN credits, saturating at
//   CREDIT_MAX. If a token would push the count past CREDIT_MAX, overflow_o is
//   set and stays set until reset.
//   Optional feature macro: LINK_UP_STATS_EN enables the 16-bit beat and word
//   counters. When it is not defined, both counter outputs are tied to zero.
module bsg_link_upstream_piso_credit #(
  parameter int CHANNELS          = 2,
  parameter int CH_WIDTH          = 8,
  parameter int PISO_DEPTH        = 4,
  parameter int CREDIT_MAX        = 16,
  parameter int CREDITS_PER_TOKEN = 8,
  localparam int IN_W             = CHANNELS * CH_WIDTH * PISO_DEPTH,
  localparam int BEAT             = CHANNELS * CH_WIDTH,
  localparam int CW               = $clog2(CREDIT_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_W-1:0]     core_data_i,
  input  logic                core_valid_i,
  output logic                core_ready_o,
  input  logic                io_token_i,
  output logic [BEAT-1:0]     io_data_r_o,
  output logic [CHANNELS-1:0] io_valid_r_o,
  output logic [CW-1:0]       credit_o,
  output logic                overflow_o,
  output logic [15:0]         sent_cnt_o,
  output logic [15:0]         word_cnt_o
);

  localparam int CTR_W = (PISO_DEPTH > 1) ? $clog2(PISO_DEPTH) : 1;
  localparam logic [CW:0]      TOKEN_INC = (CW+1)'(CREDITS_PER_TOKEN);
  localparam logic [CW:0]      CRED_MAX_W = (CW+1)'(CREDIT_MAX);
  localparam logic [CTR_W-1:0] LAST_BEAT = CTR_W'(PISO_DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, SHIFT, STALL} state_t;

  state_t            state_reg, state_next;
  logic [IN_W-1:0]   shift_reg;
  logic [CTR_W-1:0]  beat_ctr_reg;
  logic [CW-1:0]     credit_reg, credit_next;
  logic              overflow_reg;
  logic [BEAT-1:0]   io_data_reg;
  logic [CHANNELS-1:0] io_valid_reg;
  logic              send, last_beat, accept, clamp;
  logic [CW:0]       credit_sum;

  // Handshake, credit arithmetic (one extra bit to detect overshoot) and next state.
  always_comb begin
    send         = (state_reg != EMPTY) && (credit_reg != '0);
    last_beat    = (beat_ctr_reg == LAST_BEAT);
    core_ready_o = (state_reg == EMPTY) || (send && last_beat);
    accept       = core_valid_i && core_ready_o;

    credit_sum   = {1'b0, credit_reg} - {{CW{1'b0}}, send}
                 + (io_token_i ? TOKEN_INC : '0);
    clamp        = (credit_sum > CRED_MAX_W);
    credit_next  = clamp ? CW'(CREDIT_MAX) : credit_sum[CW-1:0];

    state_next   = state_reg;
    if (accept || ((state_reg != EMPTY) && !(send && last_beat))) begin
      state_next = (credit_next == '0) ? STALL : SHIFT;
    end else if (send && last_beat) begin
      state_next = EMPTY;
    end
  end

  // State register, credits and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      credit_reg   <= CW'(CREDIT_MAX);
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      credit_reg   <= credit_next;
      overflow_reg <= overflow_reg | clamp;
    end
  end

  // Word load, LSB-first shifting and the registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      beat_ctr_reg <= '0;
      io_data_reg  <= '0;
      io_valid_reg <= '0;
    end else begin
      if (send) begin
        io_data_reg  <= shift_reg[BEAT-1:0];
        io_valid_reg <= '1;
      end else begin
        io_valid_reg <= '0;
      end
      if (accept) begin
        shift_reg    <= core_data_i;
        beat_ctr_reg <= '0;
      end else if (send) begin
        shift_reg    <= shift_reg >> BEAT;
        beat_ctr_reg <= last_beat ? '0 : beat_ctr_reg + CTR_W'(1);
      end
    end
  end

  assign io_data_r_o  = io_data_reg;
  assign io_valid_r_o = io_valid_reg;
  assign credit_o     = credit_reg;
  assign overflow_o   = overflow_reg;

`ifdef LINK_UP_STATS_EN
  logic [15:0] sent_cnt_reg, word_cnt_reg;

  // Wrapping beat and word statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt_reg <= '0;
      word_cnt_reg <= '0;
    end else if (send) begin
      sent_cnt_reg <= sent_cnt_reg + 16'd1;
      if (last_beat) word_cnt_reg <= word_cnt_reg + 16'd1;
    end
  end

  assign sent_cnt_o = sent_cnt_reg;
  assign word_cnt_o = word_cnt_reg;
`else
  assign sent_cnt_o = 16'd0;
  assign word_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_bsg_link_upstream_piso_credit.sv
// tb_bsg_link_upstream_piso_credit
//   Directed bench for the upstream credit serializer with default parameters.
module tb_bsg_link_upstream_piso_credit;

  logic        clk;
  logic        rst;
  logic [63:0] core_data_i;
  logic        core_valid_i;
  logic        core_ready_o;
  logic        io_token_i;
  logic [15:0] io_data_r_o;
  logic [1:0]  io_valid_r_o;
  logic [4:0]  credit_o;
  logic        overflow_o;
  logic [15:0] sent_cnt_o;
  logic [15:0] word_cnt_o;

  int checks = 0;
  int errors = 0;

  bsg_link_upstream_piso_credit dut (
    .clk          (clk),
    .rst          (rst),
    .core_data_i  (core_data_i),
    .core_valid_i (core_valid_i),
    .core_ready_o (core_ready_o),
    .io_token_i   (io_token_i),
    .io_data_r_o  (io_data_r_o),
    .io_valid_r_o (io_valid_r_o),
    .credit_o     (credit_o),
    .overflow_o   (overflow_o),
    .sent_cnt_o   (sent_cnt_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] bv(input int w, input int k);
    return 16'hA000 + 16'(w * 16 + k);
  endfunction

  function automatic logic [63:0] word(input int w);
    return {bv(w, 3), bv(w, 2), bv(w, 1), bv(w, 0)};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    core_data_i = '0;
    core_valid_i = 1'b0;
    io_token_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_data", io_data_r_o, 16'h0);
    chk("rst_valid", io_valid_r_o, 2'b00);
    chk("rst_credit", credit_o, 5'd16);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_ready", core_ready_o, 1'b1);
    chk("rst_sent", sent_cnt_o, 16'd0);
    chk("rst_words", word_cnt_o, 16'd0);

    // 1: single word, four beats from the edge after acceptance
    core_data_i = 64'h8877_6655_4433_2211;
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    #1;
    chk("t1_load_valid", io_valid_r_o, 2'b00);
    chk("t1_load_ready", core_ready_o, 1'b0);
    tick();
    chk("t1_b0", io_data_r_o, 16'h2211);
    chk("t1_b0_valid", io_valid_r_o, 2'b11);
    chk("t1_b0_credit", credit_o, 5'd15);
    tick();
    chk("t1_b1", io_data_r_o, 16'h4433);
    chk("t1_b1_ready", core_ready_o, 1'b0);
    tick();
    chk("t1_b2", io_data_r_o, 16'h6655);
    chk("t1_last_ready", core_ready_o, 1'b1);
    tick();
    chk("t1_b3", io_data_r_o, 16'h8877);
    chk("t1_b3_credit", credit_o, 5'd12);
    tick();
    chk("t1_idle_valid", io_valid_r_o, 2'b00);
    chk("t1_idle_hold", io_data_r_o, 16'h8877);

    // 3: token at credit 12 clamps to 16 and sets the sticky overflow
    io_token_i = 1'b1;
    tick();
    io_token_i = 1'b0;
    chk("t3_credit", credit_o, 5'd16);
    chk("t3_ovf", overflow_o, 1'b1);
    repeat (3) tick();
    chk("t3_ovf_sticky", overflow_o, 1'b1);
    do_reset();
    chk("t3_ovf_cleared", overflow_o, 1'b0);

    // 2: five back-to-back words with no tokens
    core_data_i = word(0);
    core_valid_i = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k % 4 == 0) begin
        if (k < 16) core_data_i = word(k / 4 + 1);
        else core_valid_i = 1'b0;
      end
      #1;
      if (k >= 1) begin
        chk($sformatf("t2_beat%0d", k), io_data_r_o, bv((k - 1) / 4, (k - 1) % 4));
        chk($sformatf("t2_valid%0d", k), io_valid_r_o, 2'b11);
      end
      chk($sformatf("t2_credit%0d", k), credit_o, 64'(16 - k));
      chk($sformatf("t2_ready%0d", k), core_ready_o, (k % 4 == 3) ? 1'b1 : 1'b0);
    end
    tick();
    chk("t2_stall_valid", io_valid_r_o, 2'b00);
    chk("t2_stall_ready", core_ready_o, 1'b0);
    chk("t2_stall_credit", credit_o, 5'd0);
    chk("t2_stall_hold", io_data_r_o, bv(3, 3));
    io_token_i = 1'b1;
    tick();
    io_token_i = 1'b0;
    chk("t2_tok_credit", credit_o, 5'd8);
    chk("t2_tok_valid", io_valid_r_o, 2'b00);
    tick();
    chk("t2_resume_data", io_data_r_o, bv(4, 0));
    chk("t2_resume_valid", io_valid_r_o, 2'b11);
    chk("t2_resume_credit", credit_o, 5'd7);
    repeat (4) tick();

    // 4 and 6: three words, token coincides with a send at credit 5
    do_reset();
    core_data_i = word(0);
    core_valid_i = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      tick();
      if (k % 4 == 0) begin
        if (k < 8) core_data_i = word(k / 4 + 1);
        else core_valid_i = 1'b0;
      end
    end
    chk("t4_credit5", credit_o, 5'd5);
    io_token_i = 1'b1;
    tick();
    io_token_i = 1'b0;
    chk("t4_credit12", credit_o, 5'd12);
    chk("t4_data", io_data_r_o, bv(2, 3));
    chk("t4_valid", io_valid_r_o, 2'b11);
    chk("t4_ovf", overflow_o, 1'b0);
`ifdef LINK_UP_STATS_EN
    chk("t6_sent", sent_cnt_o, 16'd12);
    chk("t6_words", word_cnt_o, 16'd3);
`else
    chk("t6_sent", sent_cnt_o, 16'd0);
    chk("t6_words", word_cnt_o, 16'd0);
`endif
    tick();

    // 5: reset mid-word discards the partial word
    do_reset();
    core_data_i = word(7);
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    tick();
    tick();
    chk("t5_b1", io_data_r_o, bv(7, 1));
    rst = 1'b1;
    #1;
    chk("t5_rst_data", io_data_r_o, 16'h0);
    chk("t5_rst_valid", io_valid_r_o, 2'b00);
    chk("t5_rst_credit", credit_o, 5'd16);
    chk("t5_rst_ready", core_ready_o, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    core_data_i = word(8);
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    tick();
    chk("t5_new_b0", io_data_r_o, bv(8, 0));
    chk("t5_new_credit", credit_o, 5'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
